// File: rtl/serial_to_parallel_collector.sv
// serial_to_parallel_collector: rebuilds LSB-first serial words and queues them in a small FIFO
module serial_to_parallel_collector #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             serial_i,
    input  logic             bit_valid_i,
    output logic [WIDTH-1:0] parallel_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             frame_err_o,
    output logic             overflow_o,
    input  logic             clr_ovf_i,
    output logic             busy_o
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_par;
    logic             r_valid;
    logic             r_ferr;
    logic             r_ovf;
    logic             r_busy;

    logic             w_last;
    logic [WIDTH-1:0] w_word;
    logic             w_pop;
    logic             w_acc;
    logic             w_drop;
    logic [CW-1:0]    w_cnt_nxt;
    logic [AW:0]      w_count_nxt;
    logic [AW-1:0]    w_rp_nxt;
    logic [WIDTH-1:0] w_head;

    assign w_last      = bit_valid_i && (r_cnt == CW'(WIDTH - 1));
    assign w_word      = {serial_i, r_shift[WIDTH-2:0]};
    assign w_pop       = r_valid && ready_i;
    assign w_acc       = w_last && ((r_count < (AW+1)'(DEPTH)) || w_pop);
    assign w_drop      = w_last && !w_acc;
    assign w_cnt_nxt   = (!bit_valid_i || w_last) ? '0 : r_cnt + CW'(1);
    assign w_count_nxt = r_count + (AW+1)'(w_acc) - (AW+1)'(w_pop);
    assign w_rp_nxt    = r_rp + AW'(w_pop);
    // When the only entry left after this edge is the word being pushed, it is not in memory yet
    assign w_head      = (r_count == (AW+1)'(w_pop)) ? w_word : r_mem[w_rp_nxt];

    assign parallel_o  = r_par;
    assign valid_o     = r_valid;
    assign frame_err_o = r_ferr;
    assign overflow_o  = r_ovf;
    assign busy_o      = r_busy;

    // Word storage: data only, so it carries no reset
    always_ff @(posedge clk) begin
        if (w_acc) r_mem[r_wp] <= w_word;
    end

    // Bit collection, FIFO bookkeeping and registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_par   <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            if (bit_valid_i) r_shift[r_cnt[CW-2:0]] <= serial_i;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_cnt_nxt != '0;
            r_ferr  <= !bit_valid_i && (r_cnt != '0);
            r_wp    <= r_wp + AW'(w_acc);
            r_rp    <= w_rp_nxt;
            r_count <= w_count_nxt;
            r_valid <= w_count_nxt != '0;
            r_par   <= (w_count_nxt != '0) ? w_head : r_par;
            r_ovf   <= w_drop || (r_ovf && !clr_ovf_i);
        end
    end
endmodule
